mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive CPU-denied cycles before the CPU is force-granted; legal range 1..255.
REQ-002 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports cpu_req, input, 1 and dma_req, input, 1: access requests.
REQ-005 SHALL have ports cpu_addr/dma_addr, input, 32; cpu_wdata/dma_wdata, input, 32: address and write data.
REQ-006 SHALL have ports cpu_size/dma_size, input, 2 (MEM_SIZE_BYTE/HALF/WORD) and cpu_write/dma_write, input, 1.
REQ-007 SHALL have port dma_lock, input, 1: DMA keeps ownership across a burst.
REQ-008 SHALL have ports cpu_pause/dma_pause, output, 1: requester holds all inputs constant while high.
REQ-009 SHALL have ports cpu_rvalid/dma_rvalid, output, 1 and cpu_rdata/dma_rdata, output, 32: read response.
REQ-010 SHALL have ports bus_addr, bus_wdata, output, 32; bus_size, output, 2; bus_write, output, 1: memory-side request.
REQ-011 SHALL have ports bus_rdata, input, 32 and bus_pause, input, 1: memory-side response and stall.
REQ-012 SHALL have port arb_owner, output, 2: registered owner (0 none, 1 CPU, 2 DMA).

Function
REQ-013 SHALL compute grant gnt combinationally when bus_pause=0; when bus_pause=1, gnt SHALL equal owner_q.
REQ-014 SHALL register owner_q <= gnt every cycle.
REQ-015 SHALL grant, when bus_pause=0: DMA if owner_q=DMA, dma_lock=1 and dma_req=1; else CPU if starve guard fires (REQ-022); else DMA if dma_req; else CPU if cpu_req; else none.
REQ-016 SHALL drive bus_addr/wdata/size/write from the granted requester with zero latency; with no grant, all zero and bus_write=0.
REQ-017 SHALL drive a granted requester's pause = bus_pause; an ungranted requester's pause = its req; pause = 0 when req=0 and not granted.
REQ-018 SHALL register rd_q = (gnt != none) and bus_write=0 and bus_pause=0, plus rd_owner_q = gnt.
REQ-019 SHALL assert X_rvalid for exactly one cycle when rd_q=1 and rd_owner_q=X, i.e. one cycle after the read address is presented.
REQ-020 SHALL drive cpu_rdata and dma_rdata = bus_rdata continuously; data is meaningful only with rvalid.
REQ-021 SHALL never switch owner during a write-induced bus_pause cycle; the write completes for the original owner.
REQ-022 Starve counter: +1 per cycle with cpu_req=1 and gnt!=CPU, saturating at STARVE_LIMIT; clears when gnt=CPU or cpu_req=0; guard fires when count=STARVE_LIMIT and bus_pause=0.
REQ-023 A dma_lock burst SHALL override the starve guard; the guard fires on the first cycle after lock drops.
REQ-024 Simultaneous cpu_req and dma_req on an idle bus SHALL grant DMA.

Reset
REQ-025 On reset_n=0, owner_q=none, rd_q=0, starve count=0; all bus outputs zero; cpu_pause/dma_pause, cpu_rvalid/dma_rvalid zero; takes effect immediately, mid-transfer included.
REQ-026 SHALL not issue a bus request on the first cycle after reset release unless a req is high.

Configuration
REQ-027 SHALL have macro MEM_ARB_STARVE_GUARD_EN: when defined, the REQ-022/023 starve guard is implemented; when undefined, the counter is omitted and arbitration is strict DMA priority.

Structure
REQ-028 SHALL place typedef arb_owner_t (NONE, CPU, DMA) and the MEM_SIZE_* constants in shared package gba_mem_pkg.
REQ-029 SHALL implement the starve counter as sub-module mem_arb_starve_ctr, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-030 Verification SHALL cover: idle CPU read of 0x03000010 -> bus_addr=0x03000010 same cycle; cpu_rvalid=1 next cycle with bus_rdata; dma_rvalid=0.
REQ-031 Verification SHALL cover: cpu_req and dma_req both high on idle -> arb_owner=2 next cycle; cpu_pause=1 until DMA drops req.
REQ-032 Verification SHALL cover: DMA word write, then bus_pause=1 for one cycle while cpu_req high -> owner stays DMA through the pause; CPU granted the cycle after.
REQ-033 Verification SHALL cover: guard enabled, STARVE_LIMIT=8, DMA unlocked req held -> CPU granted on cycle 9; with dma_lock=1, CPU denied until lock drops.
REQ-034 Verification SHALL cover: reset_n low mid-burst -> all outputs zero asynchronously; after release with no req, bus_write=0.
REQ-035 Verification SHALL cover: guard undefined, DMA req held 100 cycles -> CPU never granted.

Source files
------------

// File: rtl/gba_mem_pkg.sv
// -----------------------------------------------------------------------------
// gba_mem_pkg
// Shared definitions for the memory bus arbiter slice.
//   arb_owner_t      : bus owner encoding (NONE=0, CPU=1, DMA=2); also the
//                      value presented on the arbiter's arb_owner debug port.
//   MEM_SIZE_BYTE/HALF/WORD : encodings carried on the 2-bit *_size buses.
// -----------------------------------------------------------------------------
package gba_mem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } arb_owner_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_ctr
// Counts consecutive cycles in which the CPU is requesting but not granted.
// The count saturates at LIMIT and clears whenever the CPU is granted or stops
// requesting. starve_fire tells the arbiter to force a CPU grant.
//
// Ports
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   cpu_req      : CPU request
//   cpu_granted  : arbiter's current-cycle grant is CPU
//   bus_pause    : memory stall; the guard never fires while the bus is frozen
//   starve_fire  : CPU has waited LIMIT cycles and the bus can switch now
// -----------------------------------------------------------------------------
module mem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic cpu_req,
    input  logic cpu_granted,
    input  logic bus_pause,
    output logic starve_fire
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else if (!cpu_req || cpu_granted) begin
            cnt_q <= 8'd0;
        end else if (cnt_q != LIMIT_C) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // cpu_req gates the fire so a stale saturated count cannot grant an idle CPU.
    assign starve_fire = cpu_req && !bus_pause && (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-requester (CPU, DMA) arbiter in front of a single memory bus.
// The granted requester's request passes to the bus with zero latency; reads
// return one cycle after the address is presented.
//
// Handshake: a requester raises *_req with addr/wdata/size/write. While its
// *_pause is high it must hold every request input constant; the cycle in which
// *_req=1 and *_pause=0 is the cycle the bus accepts the request. A read
// completes with *_rvalid high for one cycle (data on *_rdata). On the memory
// side, bus_pause=1 stalls the bus and freezes ownership.
//
// Configuration macro: MEM_ARB_STARVE_GUARD_EN
//   defined   : CPU is force-granted after STARVE_LIMIT denied cycles (a
//               locked DMA burst overrides this until the lock drops)
//   undefined : strict DMA priority, no starve counter
//
// Ports
//   clock, reset_n                 : clock, asynchronous active-low reset
//   cpu_req/addr/wdata/size/write  : CPU request
//   dma_req/addr/wdata/size/write  : DMA request; dma_lock holds a burst
//   cpu_pause, dma_pause           : per-requester stall
//   cpu_rvalid/rdata, dma_rvalid/rdata : read responses
//   bus_addr/wdata/size/write      : memory-side request
//   bus_rdata, bus_pause           : memory-side response and stall
//   arb_owner                      : registered owner (0 none, 1 CPU, 2 DMA)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import gba_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_write,
    output logic        cpu_pause,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,

    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_write,
    input  logic        dma_lock,
    output logic        dma_pause,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,

    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_size,
    output logic        bus_write,
    input  logic [31:0] bus_rdata,
    input  logic        bus_pause,

    output logic [1:0]  arb_owner
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("mem_bus_arbiter: STARVE_LIMIT must be within 1..255");
    end

    arb_owner_t owner_q;
    arb_owner_t rd_owner_q;
    arb_owner_t gnt;
    logic       rd_q;
    logic       starve_fire;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .LIMIT       (STARVE_LIMIT)
    ) u_starve_ctr (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_granted (gnt == CPU),
        .bus_pause   (bus_pause),
        .starve_fire (starve_fire)
    );
`else
    assign starve_fire = 1'b0;
`endif

    // Grant. reset_n is folded in so every combinational output drops to zero
    // the instant reset asserts, not just at the next edge. A stalled bus keeps
    // its owner, which is what lets a paused write finish for its originator.
    always_comb begin
        gnt = NONE;
        if (!reset_n) begin
            gnt = NONE;
        end else if (bus_pause) begin
            gnt = owner_q;
        end else if (owner_q == DMA && dma_lock && dma_req) begin
            gnt = DMA;
        end else if (starve_fire) begin
            gnt = CPU;
        end else if (dma_req) begin
            gnt = DMA;
        end else if (cpu_req) begin
            gnt = CPU;
        end
    end

    // Bus request mux: zero-latency pass-through of the granted requester.
    always_comb begin
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        bus_size  = MEM_SIZE_BYTE;
        bus_write = 1'b0;
        case (gnt)
            CPU: begin
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_size  = cpu_size;
                bus_write = cpu_write;
            end
            DMA: begin
                bus_addr  = dma_addr;
                bus_wdata = dma_wdata;
                bus_size  = dma_size;
                bus_write = dma_write;
            end
            default: begin
                bus_addr  = 32'd0;
                bus_wdata = 32'd0;
                bus_size  = MEM_SIZE_BYTE;
                bus_write = 1'b0;
            end
        endcase
    end

    // Granted requester follows the memory stall; a denied one is held off.
    always_comb begin
        cpu_pause = 1'b0;
        dma_pause = 1'b0;
        if (reset_n) begin
            cpu_pause = (gnt == CPU) ? bus_pause : cpu_req;
            dma_pause = (gnt == DMA) ? bus_pause : dma_req;
        end
    end

    // Owner state and read tracking. A read is accepted only in a cycle the
    // bus is not stalled; its data comes back on the following cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= NONE;
            rd_q       <= 1'b0;
            rd_owner_q <= NONE;
        end else begin
            owner_q    <= gnt;
            rd_q       <= (gnt != NONE) && !bus_write && !bus_pause;
            rd_owner_q <= gnt;
        end
    end

    assign cpu_rvalid = rd_q && (rd_owner_q == CPU);
    assign dma_rvalid = rd_q && (rd_owner_q == DMA);
    assign cpu_rdata  = bus_rdata;
    assign dma_rdata  = bus_rdata;
    assign arb_owner  = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Inputs change 1 time unit after a rising
// edge; combinational outputs are checked 1 unit later, registered outputs
// after the next edge. Read data expectations go through exp_q.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic        cpu_req, cpu_write, dma_req, dma_write, dma_lock, bus_pause;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, bus_rdata;
    logic [1:0]  cpu_size, dma_size;
    logic        cpu_pause, cpu_rvalid, dma_pause, dma_rvalid, bus_write;
    logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata;
    logic [1:0]  bus_size, arb_owner;

    mem_bus_arbiter #(.STARVE_LIMIT(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_size   (cpu_size),
        .cpu_write  (cpu_write),
        .cpu_pause  (cpu_pause),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_size   (dma_size),
        .dma_write  (dma_write),
        .dma_lock   (dma_lock),
        .dma_pause  (dma_pause),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_size   (bus_size),
        .bus_write  (bus_write),
        .bus_rdata  (bus_rdata),
        .bus_pause  (bus_pause),
        .arb_owner  (arb_owner)
    );

    // ---------------- scoreboard ----------------
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_rdata(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check(tag, got, e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_size = 2'd0; cpu_write = 1'b0;
        dma_req = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0; dma_size = 2'd0; dma_write = 1'b0;
        dma_lock = 1'b0; bus_pause = 1'b0; bus_rdata = 32'd0;
    endtask

    task automatic pulse_reset();
        drive_idle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int viol;
        int first;
        drive_idle();
        reset_n = 1'b0;
        #2;
        check("rst_owner",   32'(arb_owner), 32'd0);
        check("rst_bus_addr", bus_addr,      32'd0);
        check("rst_rvalid",  32'({cpu_rvalid, dma_rvalid}), 32'd0);

        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        check("post_rst_write", 32'(bus_write), 32'd0);
        step();
        check("post_rst_owner", 32'(arb_owner), 32'd0);

        // idle CPU word read
        cpu_req = 1'b1; cpu_addr = 32'h0300_0010; cpu_size = SZ_WORD; cpu_write = 1'b0;
        #1;
        check("cpu_rd_addr",  bus_addr,        32'h0300_0010);
        check("cpu_rd_size",  32'(bus_size),   32'(SZ_WORD));
        check("cpu_rd_pause", 32'(cpu_pause),  32'd0);
        exp_q.push_back(32'hCAFE_0001);
        step();
        check("cpu_rd_owner", 32'(arb_owner), 32'd1);
        cpu_req = 1'b0; bus_rdata = 32'hCAFE_0001;
        #1;
        check("cpu_rvalid",      32'(cpu_rvalid), 32'd1);
        check("cpu_rd_dmavalid", 32'(dma_rvalid), 32'd0);
        check_rdata("cpu_rdata", cpu_rdata);
        check("cpu_rd_idle_addr", bus_addr, 32'd0);
        step();
        check("cpu_rvalid_once", 32'(cpu_rvalid), 32'd0);

        // simultaneous requests: DMA write wins, CPU waits
        drive_idle();
        cpu_req = 1'b1; cpu_addr = 32'h0300_0020; cpu_size = SZ_WORD;
        dma_req = 1'b1; dma_addr = 32'h0600_0000; dma_wdata = 32'h1234_5678;
        dma_size = SZ_WORD; dma_write = 1'b1;
        #1;
        check("both_addr",      bus_addr,        32'h0600_0000);
        check("both_wdata",     bus_wdata,       32'h1234_5678);
        check("both_write",     32'(bus_write),  32'd1);
        check("both_cpu_pause", 32'(cpu_pause),  32'd1);
        check("both_dma_pause", 32'(dma_pause),  32'd0);
        step();
        check("both_owner",     32'(arb_owner),  32'd2);
        check("both_cpu_pause2", 32'(cpu_pause), 32'd1);
        check("dma_wr_norvalid", 32'(dma_rvalid), 32'd0);
        step();
        check("both_owner2",    32'(arb_owner),  32'd2);
        dma_req = 1'b0; dma_write = 1'b0;
        #1;
        check("cpu_after_dma_pause", 32'(cpu_pause), 32'd0);
        check("cpu_after_dma_addr",  bus_addr,        32'h0300_0020);
        exp_q.push_back(32'h5555_AAAA);
        step();
        check("cpu_after_dma_owner", 32'(arb_owner), 32'd1);
        cpu_req = 1'b0; bus_rdata = 32'h5555_AAAA;
        #1;
        check("cpu_after_dma_rvalid", 32'(cpu_rvalid), 32'd1);
        check_rdata("cpu_after_dma_rdata", cpu_rdata);
        drive_idle();
        step();

        // DMA halfword read
        dma_req = 1'b1; dma_addr = 32'h0600_0002; dma_size = SZ_HALF;
        #1;
        check("dma_rd_size", 32'(bus_size), 32'(SZ_HALF));
        check("dma_rd_addr", bus_addr,      32'h0600_0002);
        exp_q.push_back(32'h0000_BEEF);
        step();
        dma_req = 1'b0; bus_rdata = 32'h0000_BEEF;
        #1;
        check("dma_rvalid",     32'(dma_rvalid), 32'd1);
        check("dma_rd_cpuvalid", 32'(cpu_rvalid), 32'd0);
        check_rdata("dma_rdata", dma_rdata);
        drive_idle();
        step();

        // DMA write stalled by bus_pause while the CPU waits
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 32'h0600_0100;
        dma_wdata = 32'hA5A5_5A5A; dma_size = SZ_WORD;
        cpu_req = 1'b1; cpu_addr = 32'h0300_0030; cpu_size = SZ_WORD;
        #1;
        check("pw_first_addr", bus_addr, 32'h0600_0100);
        step();
        check("pw_owner", 32'(arb_owner), 32'd2);
        bus_pause = 1'b1;
        #1;
        check("pw_dma_pause", 32'(dma_pause), 32'd1);
        check("pw_cpu_pause", 32'(cpu_pause), 32'd1);
        check("pw_addr",      bus_addr,       32'h0600_0100);
        check("pw_write",     32'(bus_write), 32'd1);
        step();
        check("pw_owner_held", 32'(arb_owner), 32'd2);
        bus_pause = 1'b0; dma_req = 1'b0; dma_write = 1'b0;
        #1;
        check("pw_cpu_next_pause", 32'(cpu_pause), 32'd0);
        check("pw_cpu_next_addr",  bus_addr,        32'h0300_0030);
        exp_q.push_back(32'h0BAD_F00D);
        step();
        check("pw_cpu_owner", 32'(arb_owner), 32'd1);
        cpu_req = 1'b0; bus_rdata = 32'h0BAD_F00D;
        #1;
        check_rdata("pw_cpu_rdata", cpu_rdata);
        check("pw_cpu_rvalid", 32'(cpu_rvalid), 32'd1);

`ifdef MEM_ARB_STARVE_GUARD_EN
        // unlocked DMA stream: CPU forced in on cycle 9
        pulse_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0300_0040; cpu_size = SZ_WORD;
        dma_req = 1'b1; dma_addr = 32'h0600_0200; dma_size = SZ_WORD;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            if (first == 0 && cpu_pause == 1'b0) first = i;
            step();
        end
        check("starve_first_grant", 32'(first), 32'd9);

        // locked burst: CPU denied until the lock drops
        pulse_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0300_0050; cpu_size = SZ_WORD;
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h0600_0300; dma_size = SZ_WORD;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cpu_pause == 1'b0 || arb_owner == 2'd1) viol++;
            step();
        end
        check("lock_cpu_denied", 32'(viol), 32'd0);
        dma_lock = 1'b0;
        #1;
        check("lock_drop_grant", 32'(cpu_pause), 32'd0);
        check("lock_drop_addr",  bus_addr,        32'h0300_0050);
`else
        // strict priority: CPU never granted under a continuous DMA stream
        pulse_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0300_0040; cpu_size = SZ_WORD;
        dma_req = 1'b1; dma_addr = 32'h0600_0200; dma_size = SZ_WORD;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (cpu_pause == 1'b0 || arb_owner == 2'd1) viol++;
            step();
        end
        check("strict_cpu_never", 32'(viol), 32'd0);
        check("strict_owner",     32'(arb_owner), 32'd2);
`endif

        // asynchronous reset in the middle of a locked DMA write burst
        pulse_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0300_0060;
        dma_req = 1'b1; dma_lock = 1'b1; dma_write = 1'b1; dma_addr = 32'h0600_0400;
        dma_wdata = 32'hFFFF_0000; dma_size = SZ_WORD;
        step();
        step();
        check("burst_owner", 32'(arb_owner), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_owner",  32'(arb_owner), 32'd0);
        check("arst_addr",   bus_addr,        32'd0);
        check("arst_wdata",  bus_wdata,       32'd0);
        check("arst_write",  32'(bus_write),  32'd0);
        check("arst_size",   32'(bus_size),   32'd0);
        check("arst_pause",  32'({cpu_pause, dma_pause}),   32'd0);
        check("arst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
        drive_idle();
        #1;
        reset_n = 1'b1;
        step();
        check("rel_write", 32'(bus_write), 32'd0);
        check("rel_owner", 32'(arb_owner), 32'd0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
